// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between control decode, the PC sequencer and the instruction memory port.
// master is the sequencer side; slave is the decode/imem environment that drives it.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            pcMux;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            stall;
    logic            imem_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            flush;
    logic            misalign;

    modport master (
        input  pcMux, branch_target, jump, jump_target, stall, imem_ready,
        output imem_req, imem_addr, pc, pc_plus4, flush, misalign
    );

    modport slave (
        output pcMux, branch_target, jump, jump_target, stall, imem_ready,
        input  imem_req, imem_addr, pc, pc_plus4, flush, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences fetch against a req/ready imem, applies branch/jump
// redirects (deferred while imem is busy) and follows each redirect with a timed flush.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t          r_state;
    state_t          w_stateNext;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcNext;
    logic            r_pending;
    logic            w_pendingNext;
    logic [XLEN-1:0] r_pendingTarget;
    logic [XLEN-1:0] w_pendingTargetNext;
    logic [3:0]      r_flushCnt;
    logic [3:0]      w_flushCntNext;
    logic            r_misalign;
    logic            w_misalignNext;

    logic            w_redirectReq;
    logic            w_haveRedirect;
    logic [XLEN-1:0] w_rawTarget;
    logic [XLEN-1:0] w_target;

    // A fresh redirect always beats a deferred one, so the last request wins.
    assign w_redirectReq  = bus.pcMux | bus.jump;
    assign w_haveRedirect = w_redirectReq | r_pending;
    assign w_rawTarget    = bus.jump ? bus.jump_target : bus.branch_target;
    assign w_target       = w_redirectReq ? {w_rawTarget[XLEN-1:2], 2'b00} : r_pendingTarget;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_pc            <= RESET_PC;
            r_pending       <= 1'b0;
            r_pendingTarget <= '0;
            r_flushCnt      <= '0;
            r_misalign      <= 1'b0;
        end else begin
            r_state         <= w_stateNext;
            r_pc            <= w_pcNext;
            r_pending       <= w_pendingNext;
            r_pendingTarget <= w_pendingTargetNext;
            r_flushCnt      <= w_flushCntNext;
            r_misalign      <= w_misalignNext;
        end
    end

    always_comb begin
        w_stateNext         = r_state;
        w_pcNext            = r_pc;
        w_pendingNext       = r_pending;
        w_pendingTargetNext = r_pendingTarget;
        w_flushCntNext      = r_flushCnt;
        w_misalignNext      = r_misalign;

        case (r_state)
            IDLE: begin
                w_stateNext = RUN;
            end
            RUN, FLUSH: begin
                if (r_state == FLUSH) begin
                    if (r_flushCnt <= 4'd1) begin
                        w_stateNext = RUN;
                    end else begin
                        w_flushCntNext = r_flushCnt - 4'd1;
                    end
                end

                if (w_redirectReq && (w_rawTarget[1:0] != 2'b00)) begin
                    w_misalignNext = 1'b1;
                end

                // imem_req is always high here, so the PC may only move on an accepted fetch.
                if (w_haveRedirect) begin
                    if (bus.imem_ready) begin
                        w_pcNext       = w_target;
                        w_stateNext    = FLUSH;
                        w_flushCntNext = FLUSH_INIT;
                        w_pendingNext  = 1'b0;
                    end else begin
                        w_pendingNext       = 1'b1;
                        w_pendingTargetNext = w_target;
                    end
                end else if (!bus.stall && bus.imem_ready) begin
                    w_pcNext = r_pc + XLEN'(4);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.imem_req  = (r_state != IDLE);
        bus.flush     = (r_state == FLUSH);
        bus.misalign  = r_misalign;
        bus.pc        = r_pc;
        bus.imem_addr = r_pc;
        bus.pc_plus4  = r_pc + XLEN'(4);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic, each cycle's
// expected outputs come from a PC/flush/pending reference model and are checked by a monitor.
module tb_pc_sequencer;
    localparam int          XLEN         = 32;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] RESET_PC     = 32'h0;
    localparam longint      ADDR_SPACE   = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pc_sequencer_if #(.XLEN(XLEN)) sbus ();

    pc_sequencer #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(sbus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        flush;
        logic        misalign;
        logic [31:0] pc;
    } exp_t;

    exp_t expQ[$];

    int nChecks = 0;
    int nFails  = 0;

    longint mPc;
    longint mPendingTarget;
    bit     mRunning;
    bit     mHasPending;
    bit     mMisalign;
    bit     mValid = 1'b0;
    int     mFlushLeft;

    task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: one call per clock cycle with that cycle's inputs.
    task automatic modelStep(input bit rst, input bit pcMux, input logic [31:0] bt,
                             input bit jump, input logic [31:0] jt, input bit stall, input bit ready);
        exp_t   e;
        longint t;
        if (mValid) begin
            e.req      = mRunning;
            e.flush    = (mFlushLeft > 0);
            e.misalign = mMisalign;
            e.pc       = mPc[31:0];
            expQ.push_back(e);
        end
        if (rst) begin
            mPc         = longint'(RESET_PC);
            mRunning    = 1'b0;
            mFlushLeft  = 0;
            mHasPending = 1'b0;
            mMisalign   = 1'b0;
            mValid      = 1'b1;
        end else if (!mValid) begin
            mValid = 1'b0;
        end else if (!mRunning) begin
            mRunning = 1'b1;
        end else begin
            if (mFlushLeft > 0) mFlushLeft--;
            if (pcMux || jump) begin
                t = jump ? longint'(jt) : longint'(bt);
                if (t % 4 != 0) mMisalign = 1'b1;
                mPendingTarget = t - (t % 4);
                mHasPending    = 1'b1;
            end
            if (mHasPending) begin
                if (ready) begin
                    mPc         = mPendingTarget;
                    mFlushLeft  = FLUSH_CYCLES;
                    mHasPending = 1'b0;
                end
            end else if (ready && !stall) begin
                mPc = (mPc + 4) % ADDR_SPACE;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit pcMux, input logic [31:0] bt,
                                 input bit jump, input logic [31:0] jt, input bit stall, input bit ready);
        @(negedge clk);
        reset              = rst;
        sbus.pcMux         = pcMux;
        sbus.branch_target = bt;
        sbus.jump          = jump;
        sbus.jump_target   = jt;
        sbus.stall         = stall;
        sbus.imem_ready    = ready;
        modelStep(rst, pcMux, bt, jump, jt, stall, ready);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expAddr, input logic expFlush,
                               input logic expReq, input logic expMisalign);
        #1;
        compare({name, " imem_addr"}, sbus.imem_addr, expAddr);
        compare({name, " flush"}, sbus.flush, expFlush);
        compare({name, " imem_req"}, sbus.imem_req, expReq);
        compare({name, " misalign"}, sbus.misalign, expMisalign);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                compare("mon imem_req", sbus.imem_req, e.req);
                compare("mon flush", sbus.flush, e.flush);
                compare("mon misalign", sbus.misalign, e.misalign);
                compare("mon pc", sbus.pc, e.pc);
                compare("mon imem_addr", sbus.imem_addr, e.pc);
                compare("mon pc_plus4", sbus.pc_plus4, (longint'(e.pc) + 4) % ADDR_SPACE);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] bt;
        logic [31:0] jt;
        sbus.pcMux = 1'b0; sbus.branch_target = '0; sbus.jump = 1'b0;
        sbus.jump_target = '0; sbus.stall = 1'b0; sbus.imem_ready = 1'b0;

        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t1 idle", 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t1 a0", 32'h0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t1 a4", 32'h4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t1 a8", 32'h8, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t1 a12", 32'hC, 0, 1, 0);

        applyStimulus(0, 1, 32'h40, 0, 0, 0, 1); checkOutput("t2 pre", 32'h10, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t2 target", 32'h40, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t2 flush2", 32'h44, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t2 done", 32'h48, 0, 1, 0);

        applyStimulus(0, 1, 32'h80, 0, 0, 0, 0); checkOutput("t3 hold0", 32'h4C, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("t3 hold1", 32'h4C, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("t3 hold2", 32'h4C, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t3 ready", 32'h4C, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t3 target", 32'h80, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t3 flush2", 32'h84, 1, 1, 0);

        applyStimulus(0, 0, 0, 0, 0, 1, 1); checkOutput("t4 stall0", 32'h88, 0, 1, 0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 1); checkOutput($sformatf("t4 stall%0d", i), 32'h88, 0, 1, 0);
        end
        applyStimulus(0, 1, 32'h200, 1, 32'h100, 0, 1); checkOutput("t4 both", 32'h88, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 32'h103, 0, 1); checkOutput("t4 jump wins", 32'h100, 1, 1, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t5 misalign", 32'h100, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t5 sticky1", 32'h104, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t5 sticky2", 32'h108, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1); checkOutput("t5 prewrap", 32'h10C, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t5 top", 32'hFFFF_FFFC, 1, 1, 1);
        compare("t5 pc_plus4 wrap", sbus.pc_plus4, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t5 wrapped", 32'h0, 1, 1, 1);

        applyStimulus(0, 1, 32'h20, 0, 0, 0, 1); checkOutput("t6 pre", 32'h4, 0, 1, 1);
        applyStimulus(0, 1, 32'h60, 0, 0, 0, 0); checkOutput("t6 flushing", 32'h20, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0); checkOutput("t6 pending", 32'h20, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t6 reset idle", RESET_PC, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t6 run", RESET_PC, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("t6 no pending", RESET_PC + 32'h4, 0, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, bt,
                          $urandom_range(0, 14) == 0, jt, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #3;
        compare("scoreboard drained", 64'(expQ.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
